dcache_direct_mapped: RTL and testbench
=======================================

Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline MEM stage and data memory, and consumes the same data-address stream the CPU bench traces.
- Serves read hits in the request cycle and refills a full line from memory on a read miss.
- Keeps per-class hit/miss counters, so cache behaviour is checked in RTL rather than by post-processing address traces.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.
- INDEX_BITS, 4, log2 of the number of lines (16 lines).
- OFFSET_BITS, 2, log2 of words per line (4 words, 16 bytes per line).
- CNT_W, 32, statistics counter width.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  CPU access request; held with addr/we/wdata until ready_o=1
- we_i  in  1  1=write, 0=read
- addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- wdata_i  in  DATA_W  write data
- rdata_o  out  DATA_W  read data, valid when ready_o=1 and we_i=0
- ready_o  out  1  access complete; low means stall the pipeline
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  word-aligned memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse from memory
- rd_hit_o, rd_miss_o, wr_hit_o, wr_miss_o  out  CNT_W each  statistics counters

Behaviour:
- Address split:
  - word offset = addr[OFFSET_BITS+1:2]
  - index = next INDEX_BITS bits
  - tag = remaining upper bits
- Storage:
  - valid bit per line
  - tag per line
  - DATA_W x 2^OFFSET_BITS words per line
  - arrays read combinationally
- Reset (asynchronous):
  - all valid bits cleared
  - all counters 0
  - state IDLE
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0
  - ready_o=1 while req_i=0
- hit = valid[index] and tag match.
- IDLE:
  - req_i=0: ready_o=1, no action.
  - Read hit: ready_o=1 in the same cycle, rdata_o = line word; rd_hit +1; stay IDLE.
  - Read miss: ready_o=0; rd_miss +1; word counter=0; go to REFILL.
  - Write: ready_o=0; wr_hit or wr_miss +1; on a hit, update the cached word at this edge; go to WRITE.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = {tag, index, counter, 2'b00}.
  - On mem_ack_i: store mem_rdata_i into word[counter], counter +1.
  - After the ack for the last word: set valid and tag for the line; go to DONE.
  - Refill always starts at word 0; no critical-word-first.
- WRITE:
  - mem_req_o=1, mem_we_o=1, mem_addr_o = word-aligned addr_i, mem_wdata_o = wdata_i.
  - On mem_ack_i go to DONE.
  - A write miss does not allocate and leaves the line untouched.
- DONE:
  - ready_o=1 for exactly one cycle.
  - For reads, rdata_o comes from the newly filled line.
  - No counter update; return to IDLE.
- Latency:
  - read hit 0 extra cycles
  - read miss 4 acks + 2 cycles
  - write 1 ack + 2 cycles
- Each request is counted exactly once; the DONE-cycle lookup is never counted as a hit.
- Counters saturate at all-ones.
- mem_ack_i while mem_req_o=0 is ignored.
- Memory latency is arbitrary, 0 or more cycles after mem_req_o rises.
- Reset asserted mid-REFILL or mid-WRITE:
  - aborts immediately and drops mem_req_o
  - the partially filled line stays invalid
- Conflict miss replaces the line unconditionally; write-through means there is no dirty state.
- req_i deasserted while ready_o=0 is a protocol violation; behaviour is unspecified, and the bench flags it with an assertion.

Decomposition:
- Shared package, cache_pkg:
  - state enum {IDLE, REFILL, WRITE, DONE}
  - localparams for tag/index/offset widths derived from the parameters
  - address-field extraction functions
- One natural sub-module: cache_stat_counters, holding four saturating CNT_W counters with increment strobes.

Test Plan:
1. Read 0x00000040 after reset -> mem reads 0x40, 0x44, 0x48, 0x4C; ready_o 1 cycle after DONE entry; rdata_o = mem[0x40]; rd_miss=1.
2. Then read 0x00000044 -> ready_o same cycle, rdata_o = mem[0x44], no mem_req_o; rd_hit=1.
3. Read 0x00000140 (same index 4, new tag) -> refill 0x140..0x14C; then read 0x40 -> miss again; rd_miss=3.
4. Write 0xDEADBEEF to 0x148 (hit) -> one mem write; later read 0x148 hits and returns 0xDEADBEEF; wr_hit=1.
5. Write to 0x00000300 (miss) -> one mem write, no refill; read 0x300 then misses; wr_miss=1.
6. Assert rst_n=0 after the 2nd refill ack -> mem_req_o=0 immediately; counters 0; re-read of the same address misses and refills all 4 words.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM states and address-field helpers for the data cache.
package cache_pkg;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int INDEX_BITS  = 4;
   localparam int OFFSET_BITS = 2;
   localparam int CNT_W       = 32;
   localparam int TAG_BITS    = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
   localparam int LINES       = 1 << INDEX_BITS;
   localparam int WORDS       = 1 << OFFSET_BITS;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_e;

   function automatic logic [OFFSET_BITS-1:0] get_offset(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS+1:2];
   endfunction

   function automatic logic [INDEX_BITS-1:0] get_index(input logic [ADDR_W-1:0] a);
      return a[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
   endfunction

   function automatic logic [TAG_BITS-1:0] get_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:INDEX_BITS+OFFSET_BITS+2];
   endfunction
endpackage

// File: rtl/cache_stat_counters.sv
// cache_stat_counters: four saturating event counters (rd_hit, rd_miss, wr_hit, wr_miss).
module cache_stat_counters
   import cache_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic [3:0]   inc_i,
   output logic [W-1:0] rd_hit_o,
   output logic [W-1:0] rd_miss_o,
   output logic [W-1:0] wr_hit_o,
   output logic [W-1:0] wr_miss_o
);
   logic [W-1:0] cnt_q [4];

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (inc_i[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + W'(1);
      end
   end

   assign rd_hit_o  = cnt_q[0];
   assign rd_miss_o = cnt_q[1];
   assign wr_hit_o  = cnt_q[2];
   assign wr_miss_o = cnt_q[3];
endmodule

// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped: direct-mapped, write-through, no-write-allocate data cache
// with in-cycle read hits, full-line refill on read miss and hit/miss statistics.
module dcache_direct_mapped
   import cache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              ready_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [CNT_W-1:0]  rd_hit_o,
   output logic [CNT_W-1:0]  rd_miss_o,
   output logic [CNT_W-1:0]  wr_hit_o,
   output logic [CNT_W-1:0]  wr_miss_o
);
   state_e                 state_q, state_d;
   logic [OFFSET_BITS-1:0] cnt_q;
   logic [LINES-1:0]       valid_q;
   logic [TAG_BITS-1:0]    tag_q  [LINES];
   logic [DATA_W-1:0]      data_q [LINES][WORDS];
   logic [INDEX_BITS-1:0]  idx;
   logic [OFFSET_BITS-1:0] off;
   logic [TAG_BITS-1:0]    tag;
   logic                   hit, idle_req, fill_ack, last;

   assign idx      = get_index(addr_i);
   assign off      = get_offset(addr_i);
   assign tag      = get_tag(addr_i);
   assign hit      = valid_q[idx] && tag_q[idx] == tag;
   assign idle_req = state_q == IDLE && req_i;
   assign fill_ack = state_q == REFILL && mem_ack_i;
   assign last     = fill_ack && cnt_q == OFFSET_BITS'(WORDS - 1);

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = !idle_req ? IDLE : we_i ? WRITE : hit ? IDLE : REFILL;
         REFILL:  state_d = last ? DONE : REFILL;
         WRITE:   state_d = mem_ack_i ? DONE : WRITE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_o     = state_q == DONE || (state_q == IDLE && (!req_i || (!we_i && hit)));
      rdata_o     = (ready_o && req_i && !we_i) ? data_q[idx][off] : '0;
      mem_req_o   = state_q == REFILL || state_q == WRITE;
      mem_we_o    = state_q == WRITE;
      mem_addr_o  = state_q == REFILL ? {tag, idx, cnt_q, 2'b00} :
                    state_q == WRITE  ? addr_i & ~ADDR_W'(3) : '0;
      mem_wdata_o = state_q == WRITE ? wdata_i : '0;
   end

   // A line being refilled is invalidated up front so an aborted refill never looks valid.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (idle_req && !we_i && !hit) begin
            valid_q[idx] <= 1'b0;
            cnt_q        <= '0;
         end
         if (fill_ack) cnt_q <= cnt_q + OFFSET_BITS'(1);
         if (last) valid_q[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_ack) data_q[idx][cnt_q] <= mem_rdata_i;
      if (last) tag_q[idx] <= tag;
      if (idle_req && we_i && hit) data_q[idx][off] <= wdata_i;
   end

   cache_stat_counters #(.W(CNT_W)) u_stats (
      .clk_i    (clk_i),
      .rst_n    (rst_n),
      .inc_i    ({idle_req && we_i && !hit, idle_req && we_i && hit,
                  idle_req && !we_i && !hit, idle_req && !we_i && hit}),
      .rd_hit_o (rd_hit_o),
      .rd_miss_o(rd_miss_o),
      .wr_hit_o (wr_hit_o),
      .wr_miss_o(wr_miss_o)
   );
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb_dcache_direct_mapped: table-driven access vectors against a latency-configurable
// memory model, plus a mid-refill reset sequence.
module tb_dcache_direct_mapped;
   logic        clk, rst_n, req, we, ready, mreq, mwe, ack;
   logic [31:0] addr, wdata, rdata, maddr, mwdata, mrd;
   logic [31:0] rd_hit, rd_miss, wr_hit, wr_miss;
   logic [31:0] mem [256];
   logic [32:0] log_q [$];
   int          checks = 0, errors = 0, mem_cnt = 0, lat = 0, wt = 0;

   typedef struct {
      int          lat;
      logic        we;
      logic [31:0] addr, wdata, exp_rdata;
      int          exp_stall, exp_nmem;
   } vec_t;
   vec_t v [10];

   dcache_direct_mapped dut (
      .clk_i(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata), .ready_o(ready), .mem_req_o(mreq), .mem_we_o(mwe), .mem_addr_o(maddr),
      .mem_wdata_o(mwdata), .mem_rdata_i(mrd), .mem_ack_i(ack),
      .rd_hit_o(rd_hit), .rd_miss_o(rd_miss), .wr_hit_o(wr_hit), .wr_miss_o(wr_miss)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Memory model: acks lat cycles after seeing a request, one beat per ack.
   always @(negedge clk) begin
      ack = 0;
      if (!mreq) wt = 0;
      else if (wt == lat) begin
         ack = 1;
         wt = 0;
         mem_cnt++;
         log_q.push_back({mwe, maddr});
         if (mwe) mem[maddr[9:2]] = mwdata;
         else     mrd = mem[maddr[9:2]];
      end else wt++;
   end

   assert property (@(posedge clk) disable iff (!rst_n) (req && !ready) |=> req)
      else $error("req dropped while stalled");

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int stall, output int nm);
      int base = mem_cnt;
      req = 1; we = w; addr = a; wdata = d; stall = 0;
      forever begin
         @(negedge clk);
         if (ready) break;
         stall++;
         if (stall > 1000) break;
      end
      if (stall > 1000) begin
         errors++;
         $display("FAIL timeout addr=%h actual=no_ready required=ready", a);
      end
      rd = rdata;
      nm = mem_cnt - base;
      @(posedge clk);
      #1 req = 0; we = 0;
   endtask

   initial begin
      logic [31:0] rd;
      int          st, nm, base;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
      v[0] = '{0, 0, 32'h040, 0, 32'hA000_0040, 5, 4};
      v[1] = '{0, 0, 32'h044, 0, 32'hA000_0044, 0, 0};
      v[2] = '{1, 0, 32'h140, 0, 32'hA000_0140, 9, 4};
      v[3] = '{0, 0, 32'h040, 0, 32'hA000_0040, 5, 4};
      v[4] = '{0, 0, 32'h148, 0, 32'hA000_0148, 5, 4};
      v[5] = '{2, 1, 32'h148, 32'hDEAD_BEEF, 0, 4, 1};
      v[6] = '{0, 0, 32'h148, 0, 32'hDEAD_BEEF, 0, 0};
      v[7] = '{0, 1, 32'h300, 32'h1234_5678, 0, 2, 1};
      v[8] = '{0, 0, 32'h300, 0, 32'h1234_5678, 5, 4};
      v[9] = '{0, 0, 32'h304, 0, 32'hA000_0304, 0, 0};
      rst_n = 0; req = 0; we = 0; addr = 0; wdata = 0; mrd = 0; ack = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;
      chk("rst_ready", 33'(ready), 33'(1));
      chk("rst_mem_req", 33'(mreq), 33'(0));
      chk("rst_mem_addr", 33'(maddr), 33'(0));
      chk("rst_rdata", 33'(rdata), 33'(0));
      chk("rst_counters", 33'(rd_hit | rd_miss | wr_hit | wr_miss), 33'(0));

      for (int i = 0; i < 10; i++) begin
         lat = v[i].lat;
         log_q.delete();
         access(v[i].we, v[i].addr, v[i].wdata, rd, st, nm);
         if (!v[i].we) chk($sformatf("row%0d_rdata", i), 33'(rd), 33'(v[i].exp_rdata));
         chk($sformatf("row%0d_stall", i), 33'(st), 33'(v[i].exp_stall));
         chk($sformatf("row%0d_nmem", i), 33'(nm), 33'(v[i].exp_nmem));
         if (i == 0)
            for (int k = 0; k < 4; k++)
               chk($sformatf("refill_addr%0d", k), log_q.size() > k ? log_q[k] : 33'h1_FFFF_FFFF,
                   {1'b0, 32'h40 + 32'(k * 4)});
         if (i == 7) chk("wmiss_mem_write", log_q.size() > 0 ? log_q[0] : 33'h0, {1'b1, 32'h300});
      end
      chk("cnt_rd_hit", 33'(rd_hit), 33'(3));
      chk("cnt_rd_miss", 33'(rd_miss), 33'(5));
      chk("cnt_wr_hit", 33'(wr_hit), 33'(1));
      chk("cnt_wr_miss", 33'(wr_miss), 33'(1));

      // Reset lands after the second refill beat of a read miss.
      lat = 2;
      base = mem_cnt;
      req = 1; we = 0; addr = 32'h80;
      for (int k = 0; k < 200 && mem_cnt - base < 2; k++) @(negedge clk);
      chk("two_beats_seen", 33'(mem_cnt - base >= 2), 33'(1));
      @(posedge clk);
      #1 chk("mem_req_before_rst", 33'(mreq), 33'(1));
      rst_n = 0;
      #1;
      chk("mem_req_after_rst", 33'(mreq), 33'(0));
      chk("cnt_after_rst", 33'(rd_hit | rd_miss | wr_hit | wr_miss), 33'(0));
      req = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1 lat = 0;
      log_q.delete();
      access(0, 32'h80, 0, rd, st, nm);
      chk("rerd_rdata", 33'(rd), 33'(32'hA000_0080));
      chk("rerd_stall", 33'(st), 33'(5));
      chk("rerd_nmem", 33'(nm), 33'(4));
      chk("rerd_first_addr", log_q.size() > 0 ? log_q[0] : 33'h1_FFFF_FFFF, {1'b0, 32'h80});
      chk("rerd_rd_miss", 33'(rd_miss), 33'(1));
      chk("rerd_rd_hit", 33'(rd_hit), 33'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
